// File: rtl/snake_pkg.sv
// snake_pkg: shared game/collision codes, score FSM states and the 3x5 digit font
package snake_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, GAME_OVER = 2'b11} game_state_t;
    typedef enum logic [1:0] {NO_COLLISION = 2'b00, COLLISION = 2'b01, APPLE_COLLECTED = 2'b10} collision_t;
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} score_state_t;
    localparam int FONT_W = 3;
    localparam int FONT_H = 5;
    // row-major glyphs: row 0 col 0 sits in bit 14, row 4 col 2 in bit 0
    localparam logic [0:9][14:0] FONT = {
        15'b111_101_101_101_111,
        15'b010_110_010_010_111,
        15'b111_001_111_100_111,
        15'b111_001_111_001_111,
        15'b101_101_111_001_001,
        15'b111_100_111_001_111,
        15'b111_100_111_101_111,
        15'b111_001_001_001_001,
        15'b111_101_111_101_111,
        15'b111_101_111_001_111
    };
endpackage

// File: rtl/score_keeper_if.sv
// score_keeper_if: game-side inputs and overlay/score outputs of the score keeper
interface score_keeper_if #(
    parameter int BIT    = 10,
    parameter int DIGITS = 3
);
    logic [1:0]          collision_state;
    logic [1:0]          game_state;
    logic [BIT-1:0]      x_pos;
    logic [BIT-1:0]      y_pos;
    logic                score_active;
    logic [2:0]          rgb;
    logic [4*DIGITS-1:0] score_bcd;
    logic [4*DIGITS-1:0] high_score_bcd;
    modport master (
        output collision_state, game_state, x_pos, y_pos,
        input  score_active, rgb, score_bcd, high_score_bcd
    );
    modport slave (
        input  collision_state, game_state, x_pos, y_pos,
        output score_active, rgb, score_bcd, high_score_bcd
    );
endinterface

// File: rtl/score_font_rom.sv
// score_font_rom: 3x5 digit glyph lookup; spacer column and non-digits are dark
module score_font_rom
    import snake_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [2:0] row,
    input  logic [1:0] col,
    output logic       pixel
);
    logic [3:0] idx;
    assign idx   = 4'(int'(row) * FONT_W + int'(col));
    assign pixel = (digit <= 4'd9 && int'(row) < FONT_H && int'(col) < FONT_W) ? FONT[digit][4'd14 - idx] : 1'b0;
endmodule

// File: rtl/score_keeper.sv
// score_keeper: saturating BCD apple score with a frame-latched pixel-art overlay.
// Define HIGH_SCORE_EN to keep a high score and render it on a second line.
module score_keeper
    import snake_pkg::*;
#(
    parameter int         BIT         = 10,
    parameter int         DIGITS      = 3,
    parameter int         X_START     = 560,
    parameter int         Y_START     = 8,
    parameter int         SCALE_SHIFT = 2,
    parameter int         VRES        = 480,
    parameter logic [2:0] RGB_SCORE   = 3'b111,
    parameter logic [2:0] RGB_HIGH    = 3'b110
) (
    input logic           clk,
    input logic           reset,
    score_keeper_if.slave sk
);
    localparam int W = 4 * DIGITS;
    localparam int S = SCALE_SHIFT;
`ifdef HIGH_SCORE_EN
    localparam int LINES = 2;
`else
    localparam int LINES = 1;
`endif
    localparam logic [2:0] LINE_RGB [2] = '{RGB_SCORE, RGB_HIGH};

    score_state_t     state;
    logic             apple_d, apple_hit, all_nines;
    logic [W-1:0]     score, shadow, high, inc, next_score;
    logic [DIGITS:0]  carry;
    logic [W-1:0]     line_val [LINES];
    logic [LINES-1:0] line_on;

    assign apple_hit = sk.collision_state == APPLE_COLLECTED && !apple_d;
    assign carry[0]  = 1'b1;
    for (genvar d = 0; d < DIGITS; d++) begin : g_inc
        assign inc[4*d +: 4] = !carry[d] ? score[4*d +: 4] : score[4*d +: 4] == 4'd9 ? 4'd0 : score[4*d +: 4] + 4'd1;
        assign carry[d+1]    = carry[d] && score[4*d +: 4] == 4'd9;
    end
    assign all_nines  = carry[DIGITS];
    assign next_score = apple_hit && !all_nines ? inc : score;

    // the high-score compare sees next_score so a final apple on GAME_OVER still counts
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            score   <= '0;
            shadow  <= '0;
            apple_d <= 1'b0;
`ifdef HIGH_SCORE_EN
            high    <= '0;
`endif
        end else begin
            apple_d <= sk.collision_state == APPLE_COLLECTED;
            if (sk.x_pos == '0 && sk.y_pos == BIT'(VRES)) shadow <= score;
            case (state)
                S_IDLE: if (sk.game_state == PLAY) begin
                    state <= S_PLAY;
                    score <= '0;
                end
                S_PLAY: begin
                    score <= next_score;
                    if (sk.game_state == GAME_OVER) begin
                        state <= S_OVER;
`ifdef HIGH_SCORE_EN
                        if (next_score > high) high <= next_score;
`endif
                    end else if (sk.game_state == IDLE) state <= S_IDLE;
                end
                S_OVER: if (sk.game_state == IDLE) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HIGH_SCORE_EN
    assign line_val[1] = high;
`else
    assign high = '0;
`endif
    assign line_val[0] = shadow;

    for (genvar l = 0; l < LINES; l++) begin : g_line
        int         dx, dy;
        logic [3:0] digit;
        logic       in_box, pixel;
        assign dx     = int'(sk.x_pos) - X_START;
        assign dy     = int'(sk.y_pos) - (Y_START + l * (6 << S));
        assign in_box = dx >= 0 && dx < DIGITS * (4 << S) && dy >= 0 && dy < (FONT_H << S);
        always_comb begin
            digit = '0;
            for (int i = 0; i < DIGITS; i++) if ((dx >> (S + 2)) == i) digit = line_val[l][W-4-4*i +: 4];
        end
        score_font_rom u_rom (.digit(digit), .row(3'(dy >> S)), .col(2'(dx >> S)), .pixel(pixel));
        assign line_on[l] = in_box && pixel;
    end

    assign sk.score_active   = |line_on;
    assign sk.score_bcd      = score;
    assign sk.high_score_bcd = high;
    always_comb begin
        sk.rgb = 3'b000;
        for (int i = 0; i < LINES; i++) if (line_on[i]) sk.rgb = LINE_RGB[i];
    end
endmodule
